apb_master: RTL and testbench

APB_MASTER -- requirements
Module: apb_master

---
 rtl/apb_master.sv | 149 ++++++++++++++
 tb/tb_apb_master.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_master.sv
// APB master burst engine: turns one command (addr/len/size/dir) into a
// sequence of APB transfers. Write data comes from a FWFT write FIFO and
// read data goes to a read FIFO. Each beat runs LOAD -> SETUP -> ACCESS.
module apb_master #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  // command channel from the bridge engine
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [7:0]            cmd_len,
  input  logic [2:0]            cmd_size,
  // write FIFO (first-word-fall-through)
  input  logic                  wr_fifo_empty,
  input  logic [DATA_WIDTH-1:0] wr_fifo_data,
  output logic                  wr_fifo_read,
  // read FIFO
  input  logic                  rd_fifo_full,
  output logic                  rd_fifo_write,
  output logic [DATA_WIDTH-1:0] rd_fifo_data,
  // APB
  output logic                  psel,
  output logic                  penable,
  output logic                  pwrite,
  output logic [ADDR_WIDTH-1:0] paddr,
  output logic [DATA_WIDTH-1:0] pwdata,
  input  logic [DATA_WIDTH-1:0] prdata,
  input  logic                  pready,
  input  logic                  pslverr,
  // burst completion
  output logic                  done,
  output logic                  err
);

  typedef enum logic [2:0] {IDLE, LOAD, SETUP, ACCESS, DONE} state_t;

  state_t                state_q;
  logic                  pwrite_q;
  logic [ADDR_WIDTH-1:0] paddr_q;
  logic [ADDR_WIDTH-1:0] paddr_d;
  logic [DATA_WIDTH-1:0] pwdata_q;
  logic [7:0]            len_q;
  logic [7:0]            beat_q;
  logic [2:0]            size_q;
  logic                  psel_q;
  logic                  penable_q;
  logic                  done_q;
  logic                  err_q;
  logic                  err_flag_q;

  // Next beat address; wraps naturally at 2^ADDR_WIDTH, no page-boundary check.
  assign paddr_d = paddr_q + (ADDR_WIDTH'(1) << size_q);

  // Burst FSM with registered APB controls and completion strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      pwrite_q   <= 1'b0;
      paddr_q    <= '0;
      pwdata_q   <= '0;
      len_q      <= '0;
      beat_q     <= '0;
      size_q     <= '0;
      psel_q     <= 1'b0;
      penable_q  <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      err_flag_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (cmd_valid) begin
            pwrite_q   <= cmd_write;
            paddr_q    <= cmd_addr;
            len_q      <= cmd_len;
            size_q     <= cmd_size;
            beat_q     <= '0;
            err_flag_q <= 1'b0;
            state_q    <= LOAD;
          end
        end
        LOAD: begin
          // Only start a beat once its data (write) or its slot (read) exists.
          if (pwrite_q) begin
            if (!wr_fifo_empty) begin
              pwdata_q <= wr_fifo_data;
              psel_q   <= 1'b1;
              state_q  <= SETUP;
            end
          end else if (!rd_fifo_full) begin
            psel_q  <= 1'b1;
            state_q <= SETUP;
          end
        end
        SETUP: begin
          penable_q <= 1'b1;
          state_q   <= ACCESS;
        end
        ACCESS: begin
          if (pready) begin
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            // Errors are sticky and never abort: every beat still moves a word.
            if (pslverr) err_flag_q <= 1'b1;
            if (beat_q == len_q) begin
              done_q  <= 1'b1;
              err_q   <= err_flag_q | pslverr;
              state_q <= DONE;
            end else begin
              beat_q  <= beat_q + 8'd1;
              paddr_q <= paddr_d;
              state_q <= LOAD;
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // FIFO handshakes are same-cycle with the FIFO status, so they are decoded;
  // gating with rst keeps a word from being popped/pushed while being reset.
  always_comb begin
    wr_fifo_read  = !rst && (state_q == LOAD) && pwrite_q && !wr_fifo_empty;
    rd_fifo_write = !rst && (state_q == ACCESS) && !pwrite_q && pready;
    rd_fifo_data  = rd_fifo_write ? prdata : '0;
  end

  assign cmd_ready = (state_q == IDLE);
  assign psel      = psel_q;
  assign penable   = penable_q;
  assign pwrite    = pwrite_q;
  assign paddr     = paddr_q;
  assign pwdata    = pwdata_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_apb_master.sv
// Directed bench for apb_master: cycle-exact checks of each beat phase,
// FIFO stalls, sticky error, address wrap and reset during ACCESS.
module tb_apb_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr;
  logic [7:0]  cmd_len;
  logic [2:0]  cmd_size;
  logic        wr_fifo_empty, wr_fifo_read;
  logic [31:0] wr_fifo_data;
  logic        rd_fifo_full, rd_fifo_write;
  logic [31:0] rd_fifo_data;
  logic        psel, penable, pwrite;
  logic [31:0] paddr, pwdata, prdata;
  logic        pready, pslverr;
  logic        done, err;

  int checks = 0;
  int errors = 0;
  int pops   = 0;
  int pushes = 0;
  int both   = 0;
  int p0;

  always #5 clk = ~clk;

  apb_master #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_size(cmd_size),
    .wr_fifo_empty(wr_fifo_empty), .wr_fifo_data(wr_fifo_data), .wr_fifo_read(wr_fifo_read),
    .rd_fifo_full(rd_fifo_full), .rd_fifo_write(rd_fifo_write), .rd_fifo_data(rd_fifo_data),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
    .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr),
    .done(done), .err(err)
  );

  `define CHK(tag, obs, exp) \
    begin \
      checks++; \
      assert ((obs) === (exp)) else begin \
        errors++; \
        $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp); \
      end \
    end

  always @(negedge clk) begin
    if (!rst) begin
      if (wr_fifo_read) pops++;
      if (rd_fifo_write) pushes++;
      if (wr_fifo_read && rd_fifo_write) both++;
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      checks++;
      if ((wr_fifo_read && rd_fifo_write) !== 1'b0) begin
        errors++;
        $error("FAIL mon_both observed=1 expected=0");
      end
      checks++;
      if ((cmd_ready && (psel || penable)) !== 1'b0) begin
        errors++;
        $error("FAIL mon_idle_apb psel=%0b penable=%0b expected=0", psel, penable);
      end
      checks++;
      if ((penable && !psel) !== 1'b0) begin
        errors++;
        $error("FAIL mon_penable_no_psel observed=1 expected=0");
      end
      checks++;
      if ((done && (psel || penable)) !== 1'b0) begin
        errors++;
        $error("FAIL mon_done_apb observed=1 expected=0");
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic wr, input logic [31:0] a, input logic [7:0] len,
                       input logic [2:0] sz);
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_len = len; cmd_size = sz;
    #1;
    `CHK("cmd_ready_idle", cmd_ready, 1'b1)
    step();
    cmd_valid = 1'b0;
    #1;
  endtask

  task automatic beat(input logic wr, input logic [31:0] a, input logic [31:0] wd,
                      input logic [31:0] rd, input int waits, input logic slverr);
    `CHK("load_psel", psel, 1'b0)
    `CHK("load_pop", wr_fifo_read, wr)
    step();
    `CHK("setup_psel", psel, 1'b1)
    `CHK("setup_penable", penable, 1'b0)
    `CHK("setup_paddr", paddr, a)
    `CHK("setup_pwrite", pwrite, wr)
    if (wr) `CHK("setup_pwdata", pwdata, wd)
    pready = 1'b0;
    for (int i = 0; i < waits; i++) begin
      step();
      `CHK("wait_penable", penable, 1'b1)
      `CHK("wait_nopush", rd_fifo_write, 1'b0)
      `CHK("wait_paddr", paddr, a)
    end
    step();
    pready = 1'b1; prdata = rd; pslverr = slverr;
    #1;
    `CHK("access_psel", psel, 1'b1)
    `CHK("access_penable", penable, 1'b1)
    `CHK("access_paddr", paddr, a)
    if (wr) `CHK("access_pwdata", pwdata, wd)
    `CHK("access_push", rd_fifo_write, !wr)
    if (!wr) `CHK("access_rdata", rd_fifo_data, rd)
    step();
    pslverr = 1'b0;
    #1;
  endtask

  task automatic check_done(input logic exp_err);
    `CHK("done_pulse", done, 1'b1)
    `CHK("done_err", err, exp_err)
    `CHK("done_psel", psel, 1'b0)
    step();
    `CHK("done_clear", done, 1'b0)
    `CHK("idle_ready", cmd_ready, 1'b1)
  endtask

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_len = '0;
    cmd_size = '0; wr_fifo_empty = 1'b0; wr_fifo_data = '0; rd_fifo_full = 1'b0;
    prdata = '0; pready = 1'b1; pslverr = 1'b0;
    step(); step();
    `CHK("rst_ready", cmd_ready, 1'b1)
    `CHK("rst_psel", psel, 1'b0)
    `CHK("rst_penable", penable, 1'b0)
    `CHK("rst_pwrite", pwrite, 1'b0)
    `CHK("rst_paddr", paddr, 32'h0)
    `CHK("rst_pwdata", pwdata, 32'h0)
    `CHK("rst_done", done, 1'b0)
    `CHK("rst_err", err, 1'b0)
    `CHK("rst_pop", wr_fifo_read, 1'b0)
    `CHK("rst_push", rd_fifo_write, 1'b0)
    `CHK("rst_rdata", rd_fifo_data, 32'h0)
    rst = 1'b0;
    step();

    p0 = pops;
    wr_fifo_data = 32'hDEADBEEF;
    issue(1'b1, 32'h1000, 8'd0, 3'd2);
    beat(1'b1, 32'h1000, 32'hDEADBEEF, 32'h0, 0, 1'b0);
    check_done(1'b0);
    `CHK("wr1_pops", pops - p0, 1)

    p0 = pushes;
    issue(1'b0, 32'h2000, 8'd3, 3'd2);
    beat(1'b0, 32'h2000, 32'h0, 32'h11, 2, 1'b0);
    beat(1'b0, 32'h2004, 32'h0, 32'h22, 2, 1'b0);
    beat(1'b0, 32'h2008, 32'h0, 32'h33, 2, 1'b0);
    beat(1'b0, 32'h200C, 32'h0, 32'h44, 2, 1'b0);
    check_done(1'b0);
    `CHK("rd4_pushes", pushes - p0, 4)

    p0 = pops;
    wr_fifo_data = 32'hA1;
    issue(1'b1, 32'h3000, 8'd1, 3'd2);
    wr_fifo_empty = 1'b0;
    #1;
    beat(1'b1, 32'h3000, 32'hA1, 32'h0, 0, 1'b0);
    wr_fifo_empty = 1'b1; wr_fifo_data = 32'hB2;
    #1;
    for (int i = 0; i < 5; i++) begin
      `CHK("empty_psel", psel, 1'b0)
      `CHK("empty_nopop", wr_fifo_read, 1'b0)
      if (i < 4) step();
    end
    step();
    wr_fifo_empty = 1'b0;
    #1;
    beat(1'b1, 32'h3004, 32'hB2, 32'h0, 0, 1'b0);
    check_done(1'b0);
    `CHK("stall_pops", pops - p0, 2)

    rd_fifo_full = 1'b1;
    issue(1'b0, 32'h4000, 8'd0, 3'd2);
    for (int i = 0; i < 3; i++) begin
      `CHK("full_psel", psel, 1'b0)
      `CHK("full_nopush", rd_fifo_write, 1'b0)
      step();
    end
    rd_fifo_full = 1'b0;
    #1;
    beat(1'b0, 32'h4000, 32'h0, 32'h55, 0, 1'b0);
    check_done(1'b0);

    p0 = pushes;
    issue(1'b0, 32'h5000, 8'd1, 3'd2);
    beat(1'b0, 32'h5000, 32'h0, 32'hA0, 1, 1'b1);
    beat(1'b0, 32'h5004, 32'h0, 32'hB0, 0, 1'b0);
    check_done(1'b1);
    `CHK("slverr_pushes", pushes - p0, 2)
    issue(1'b0, 32'h6000, 8'd0, 3'd0);
    beat(1'b0, 32'h6000, 32'h0, 32'h66, 0, 1'b0);
    check_done(1'b0);

    wr_fifo_data = 32'hC1;
    issue(1'b1, 32'hFFFFFFFC, 8'd1, 3'd2);
    beat(1'b1, 32'hFFFFFFFC, 32'hC1, 32'h0, 0, 1'b0);
    `CHK("wrap_load_pop", wr_fifo_read, 1'b1)
    step();
    `CHK("wrap_paddr", paddr, 32'h0)
    `CHK("wrap_setup_psel", psel, 1'b1)
    pready = 1'b0;
    step();
    `CHK("wrap_access_penable", penable, 1'b1)
    rst = 1'b1;
    step();
    `CHK("rst_access_psel", psel, 1'b0)
    `CHK("rst_access_penable", penable, 1'b0)
    `CHK("rst_access_ready", cmd_ready, 1'b1)
    `CHK("rst_access_done", done, 1'b0)
    rst = 1'b0; pready = 1'b1;
    step();
    `CHK("post_rst_idle", cmd_ready, 1'b1)
    `CHK("never_both", both, 0)

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
